prog_loader: RTL

Boot-time program loader: the write side of the CPU's byte-addressed, little-endian instruction memory. It accepts a framed byte stream over a valid/ready handshake and checks its length and checksum. Each payload byte is written into instruction memory at consecutive addresses from 0. The CPU is held until a frame completes cleanly. The block sits between the host/debug byte source and the instruction memory write port, and drives the CPU's `cpu_hold`.

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Frame: LEN_LO, LEN_HI, payload bytes, CSUM (8-bit sum of payload).
package prog_loader_pkg;

  localparam int LEN_BYTES = 2;
  localparam int CSUM_W    = 8;
  localparam int LEN_W     = LEN_BYTES * 8;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream and writes the payload into
// instruction memory from address 0, releasing the CPU only on a clean frame.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output loader_state_t     dbg_state
);

  // Handshake: a byte transfers on a rising edge where s_valid & s_ready.
  // s_ready is high while receiving (LEN_LO..CSUM) and is forced low by start.

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_BYTES);

  loader_state_t       state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CSUM_W-1:0]   csum_q, csum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;

  logic                hs;
  logic [LEN_W-1:0]    frame_len;
  logic [CNT_W-1:0]    next_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LEN_LO;
      len_lo_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      csum_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    s_ready   = 1'b0;
    frame_len = {s_data, len_lo_q};
    next_cnt  = cnt_q + 1'b1;

    case (state_q)
      LEN_LO, LEN_HI, DATA, CSUM: s_ready = ~start;
      default:                    s_ready = 1'b0;
    endcase
    hs = s_valid & s_ready;

    // The registered write from the previous edge still drives the port this
    // cycle even when start aborts; only new acceptance is suppressed.
    if (start) begin
      state_d  = LEN_LO;
      len_lo_d = '0;
      len_d    = '0;
      cnt_d    = '0;
      csum_d   = '0;
    end else if (hs) begin
      case (state_q)
        LEN_LO: begin
          len_lo_d = s_data;
          state_d  = LEN_HI;
        end
        LEN_HI: begin
          if (frame_len != '0 && frame_len <= MAX_N) begin
            len_d   = frame_len[CNT_W-1:0];
            cnt_d   = '0;
            state_d = DATA;
          end else begin
            state_d = ERR;
          end
        end
        DATA: begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = s_data;
          csum_d  = csum_q + s_data;
          cnt_d   = next_cnt;
          if (next_cnt == len_q) state_d = CSUM;
        end
        CSUM: begin
          state_d = (s_data == csum_q) ? DONE : ERR;
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);
  assign cpu_hold  = ~done;
  assign dbg_state = state_q;

endmodule
